multi_core_dispatcher: RTL and testbench
========================================

# multi_core_dispatcher

Parametrised successor to the single-kernel dispatcher that sits between the GPU top level and its cores. It distributes `num_blocks` thread blocks across `NUM_CORES` cores, one block per core at a time. Each core is reset and then started per block, and completions are counted. It adds abort, live status counters and same-cycle completion/dispatch across different cores.

## Interface
Parameters:
- `NUM_CORES`, 2: number of cores served; 1..32.
- `BLOCK_ID_WIDTH`, 8: width of a block ID; counters are `BLOCK_ID_WIDTH+1` bits wide.

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `reset` in 1: asynchronous, active-low. Low clears all state immediately.
- `start` in 1: launch request; sampled in IDLE or DONE.
- `abort` in 1: cancel the kernel in progress; sampled in RUN.
- `num_blocks` in `BLOCK_ID_WIDTH+1`: block count, latched on start accept.
- `core_done` in `NUM_CORES`: per-core level, "block finished".
- `core_start` out `NUM_CORES`: per-core run enable; held high until that core's done is seen.
- `core_reset` out `NUM_CORES`: per-core one-cycle reset pulse, active-high.
- `core_block_id` out `NUM_CORES` x `BLOCK_ID_WIDTH`: ID of the block assigned to each core.
- `blocks_dispatched` out `BLOCK_ID_WIDTH+1`: running count of blocks issued.
- `blocks_done` out `BLOCK_ID_WIDTH+1`: running count of blocks completed.
- `busy` out 1: high in RUN.
- `done` out 1: high in DONE.

## Operation
- The FSM has three states: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - `start`=1 latches `num_blocks` and clears both counters.
  - If `num_blocks`≠0, go to RUN; if `num_blocks`=0, go to DONE.
- RUN, dispatch:
  - At most one dispatch per cycle, while `blocks_dispatched` < `num_blocks`.
  - The target is the lowest-index free core.
  - Dispatch pulses `core_reset[i]` for one cycle and loads `core_block_id[i]` with the low bits of `blocks_dispatched`. The counter increments in the same cycle.
  - The next cycle raises `core_start[i]`.
- RUN, completion:
  - A core completes in any cycle where `core_start[i]` & `core_done[i]`.
  - `core_start[i]` drops the next cycle, and `blocks_done` increments by the popcount of completing cores.
  - A core becomes free in the cycle after `core_start` drops. It is never re-dispatched in the cycle it completes.
- Completion on some cores and dispatch to a different core in the same cycle are both honoured.
- `core_done[i]` is ignored while `core_start[i]`=0. A stale done level is cleared by that core's reset pulse.
- RUN to DONE: when the updated `blocks_done` equals `num_blocks`.
- Abort in RUN:
  - All `core_start` drop, and all `core_reset` pulse for one cycle.
  - The FSM returns to IDLE and `done` stays low.
  - Counters hold their values for inspection until the next start.
  - Abort has priority over completion in the same cycle.
- DONE: `done` is held. `start`=1 re-launches exactly as from IDLE, and `done` drops the next cycle.
- `start` in RUN is ignored.
- Reset values: state IDLE; `core_start`=0, `core_reset`=0, `core_block_id`=0; both counters 0; `busy`=0, `done`=0.
- When `reset` goes low mid-kernel, all outputs clear asynchronously and no core pulse is generated.

## Timing
- Cycle n: `start` sampled.
- n+1: `busy`=1.
- n+2: `core_reset[0]`=1 with `core_block_id[0]`=0.
- n+3: `core_start[0]`=1, and `core_reset[1]` is pulsed with ID 1.
- Best case, K free cores are all running by n+2+K.
- Completion to start-low latency is one cycle; completion to re-dispatch of the same core is at least two cycles.
- The final completion at cycle m gives `done`=1 and `busy`=0 at m+1.
- Abort at cycle m gives the `core_reset` pulse and IDLE at m+1.
- `num_blocks`=0 gives `done` at n+1, with no core activity.
- Maximum `num_blocks` = 2^`BLOCK_ID_WIDTH`. The IDs issued are 0..2^`BLOCK_ID_WIDTH`-1, with no wrap within one kernel.

## Structure
- Shared package holds:
  - the `dispatcher_state_t` enum (IDLE/RUN/DONE);
  - `block_count_t`, which is `BLOCK_ID_WIDTH+1` wide;
  - `block_id_t`.
- Per-core state is a `core_busy` vector plus the `core_start` vector; no per-core FSM.
- One sub-module: `lowest_free_core`, a parametrised find-first-set over `~core_busy`. It outputs `index` and `valid`.

## Test plan
- NUM_CORES=2, `num_blocks`=5, each core answers done 4 cycles after start:
  - IDs 0..4 are issued alternately; no core gets two outstanding blocks.
  - `done` rises one cycle after the 5th completion; `blocks_done`=5.
- `num_blocks`=0: `done`=1 at n+1, and `core_reset` and `core_start` never assert.
- Both cores raise done in the same cycle with 3 blocks pending:
  - `blocks_done` increments by 2 in one cycle.
  - The next two dispatches go to core 0 then core 1, on consecutive cycles.
- Abort two cycles after the first dispatch:
  - All `core_reset` pulse once, and all `core_start` are 0 the next cycle.
  - The FSM is in IDLE, `done`=0, and the counters hold.
- `reset` driven low mid-RUN, asynchronously between edges: all outputs are 0 before the next edge; the FSM is in IDLE after release.
- `BLOCK_ID_WIDTH`=3, `num_blocks`=8:
  - The last ID issued is 7, `blocks_dispatched`=8, and `done` follows.
  - A second `start` from DONE re-runs the kernel with the counters cleared.

Source files
------------

// File: rtl/multi_core_dispatcher_pkg.sv
// Shared types and helpers for the multi-core block dispatcher.
package multi_core_dispatcher_pkg;

  // Default block-ID width; the top module takes it as its parameter default.
  localparam int DEFAULT_BLOCK_ID_WIDTH = 8;

  // Largest core count the dispatcher supports.
  localparam int MAX_CORES = 32;

  // Kernel-level FSM state, also exported on the debug port.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dispatcher_state_t;

  // Counter and ID types for the default width. Counters are one bit wider
  // than IDs so a full 2^BLOCK_ID_WIDTH kernel can be counted without a wrap.
  typedef logic [DEFAULT_BLOCK_ID_WIDTH:0]   block_count_t;
  typedef logic [DEFAULT_BLOCK_ID_WIDTH-1:0] block_id_t;

  // Number of set bits in a core vector, zero-extended to MAX_CORES bits.
  function automatic logic [5:0] popcount(input logic [MAX_CORES-1:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_CORES; i++) begin
      cnt = cnt + 6'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/multi_core_dispatcher_lowest_free_core.sv
// Find-first-set over the free-core vector: lowest free index wins.
module lowest_free_core #(
  parameter int N       = 2,
  parameter int INDEX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]       free,
  output logic [INDEX_W-1:0] index,
  output logic               valid
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (free[i]) begin
        index = INDEX_W'(i);
      end
    end
    valid = |free;
  end

endmodule

// File: rtl/multi_core_dispatcher.sv
// Multi-core dispatcher: hands out num_blocks thread blocks to NUM_CORES
// cores, one block per core at a time, and counts completions.
//
// Kernel handshake: start is a request sampled only in IDLE or DONE; it is
// accepted on that edge (no ready needed), busy is high for the whole RUN
// phase and done is a level held from the final completion until the next
// accepted start. Per core, core_reset is a one-cycle pulse carrying a new
// core_block_id, core_start then stays high until the first cycle where
// core_start & core_done are both high; core_done is ignored otherwise.
module multi_core_dispatcher
  import multi_core_dispatcher_pkg::*;
#(
  parameter int NUM_CORES      = 2,
  parameter int BLOCK_ID_WIDTH = DEFAULT_BLOCK_ID_WIDTH
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic                                     abort,
  input  logic [BLOCK_ID_WIDTH:0]                  num_blocks,
  input  logic [NUM_CORES-1:0]                     core_done,
  output logic [NUM_CORES-1:0]                     core_start,
  output logic [NUM_CORES-1:0]                     core_reset,
  output logic [NUM_CORES-1:0][BLOCK_ID_WIDTH-1:0] core_block_id,
  output logic [BLOCK_ID_WIDTH:0]                  blocks_dispatched,
  output logic [BLOCK_ID_WIDTH:0]                  blocks_done,
  output logic                                     busy,
  output logic                                     done,
  output dispatcher_state_t                        fsm_state
);

  localparam int CW = BLOCK_ID_WIDTH + 1;
  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  dispatcher_state_t state, state_n;

  logic [CW-1:0]        num_q, num_n;
  logic [NUM_CORES-1:0] core_busy, core_busy_n;

  logic [NUM_CORES-1:0]                     core_start_n;
  logic [NUM_CORES-1:0]                     core_reset_n;
  logic [NUM_CORES-1:0][BLOCK_ID_WIDTH-1:0] core_block_id_n;
  logic [CW-1:0]                            dispatched_n;
  logic [CW-1:0]                            done_cnt_n;
  logic                                     busy_n;
  logic                                     done_n;

  logic [NUM_CORES-1:0] completing;
  logic [CW-1:0]        done_sum;
  logic [IW-1:0]        free_index;
  logic                 free_valid;

  assign fsm_state = state;

  // A core only completes while it is actually running.
  assign completing = core_start & core_done;
  assign done_sum   = blocks_done + CW'(popcount(MAX_CORES'(completing)));

  lowest_free_core #(
    .N       (NUM_CORES),
    .INDEX_W (IW)
  ) u_free (
    .free  (~core_busy),
    .index (free_index),
    .valid (free_valid)
  );

  // Next-state and next-output logic for the kernel FSM and per-core state.
  always_comb begin
    state_n         = state;
    core_start_n    = core_start;
    core_reset_n    = '0;
    core_block_id_n = core_block_id;
    // A core stays busy while resetting or running; once start has dropped
    // it frees on the following edge, so it is never re-issued in the cycle
    // it completes.
    core_busy_n     = core_busy & (core_start | core_reset);
    dispatched_n    = blocks_dispatched;
    done_cnt_n      = blocks_done;
    num_n           = num_q;
    busy_n          = busy;
    done_n          = done;

    unique case (state)
      IDLE, DONE: begin
        core_start_n = '0;
        if (start) begin
          num_n        = num_blocks;
          dispatched_n = '0;
          done_cnt_n   = '0;
          if (num_blocks != '0) begin
            state_n = RUN;
            busy_n  = 1'b1;
            done_n  = 1'b0;
          end else begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
      end

      RUN: begin
        if (abort) begin
          // Abort beats any completion in the same cycle; counters hold.
          state_n      = IDLE;
          core_start_n = '0;
          core_reset_n = '1;
          core_busy_n  = '0;
          busy_n       = 1'b0;
          done_n       = 1'b0;
        end else begin
          // Completing cores drop start; last cycle's reset pulse raises it.
          core_start_n = (core_start & ~completing) | core_reset;
          done_cnt_n   = done_sum;
          if (done_sum == num_q) begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else if (free_valid && (blocks_dispatched < num_q)) begin
            core_reset_n[free_index]    = 1'b1;
            core_block_id_n[free_index] = blocks_dispatched[BLOCK_ID_WIDTH-1:0];
            core_busy_n[free_index]     = 1'b1;
            dispatched_n                = blocks_dispatched + CW'(1);
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Registered outputs and per-core bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_q             <= '0;
      core_busy         <= '0;
      core_start        <= '0;
      core_reset        <= '0;
      core_block_id     <= '0;
      blocks_dispatched <= '0;
      blocks_done       <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      num_q             <= num_n;
      core_busy         <= core_busy_n;
      core_start        <= core_start_n;
      core_reset        <= core_reset_n;
      core_block_id     <= core_block_id_n;
      blocks_dispatched <= dispatched_n;
      blocks_done       <= done_cnt_n;
      busy              <= busy_n;
      done              <= done_n;
    end
  end

endmodule

// File: tb/tb_multi_core_dispatcher.sv
// Bench for multi_core_dispatcher: a table of kernels on a 2-core, 8-bit-ID
// instance plus hand-written multi-cycle sequences, and a 3-bit-ID instance
// for the full-range kernel.
module tb_multi_core_dispatcher;
  import multi_core_dispatcher_pkg::*;

  localparam int LAT = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: 2 cores, 8-bit IDs ----------------
  logic            start_a = 1'b0;
  logic            abort_a = 1'b0;
  logic [8:0]      num_a   = '0;
  logic [1:0]      core_done_a;
  logic [1:0]      core_start_a, core_reset_a;
  logic [1:0][7:0] id_a;
  logic [8:0]      disp_a, bdone_a;
  logic            busy_a, done_a;
  dispatcher_state_t state_a;

  multi_core_dispatcher #(.NUM_CORES(2), .BLOCK_ID_WIDTH(8)) dut_a (
    .clk(clk), .reset(rst_n), .start(start_a), .abort(abort_a),
    .num_blocks(num_a), .core_done(core_done_a), .core_start(core_start_a),
    .core_reset(core_reset_a), .core_block_id(id_a),
    .blocks_dispatched(disp_a), .blocks_done(bdone_a),
    .busy(busy_a), .done(done_a), .fsm_state(state_a)
  );

  // ---------------- DUT B: 2 cores, 3-bit IDs ----------------
  logic            start_b = 1'b0;
  logic            abort_b = 1'b0;
  logic [3:0]      num_b   = '0;
  logic [1:0]      core_done_b;
  logic [1:0]      core_start_b, core_reset_b;
  logic [1:0][2:0] id_b;
  logic [3:0]      disp_b, bdone_b;
  logic            busy_b, done_b;
  dispatcher_state_t state_b;

  multi_core_dispatcher #(.NUM_CORES(2), .BLOCK_ID_WIDTH(3)) dut_b (
    .clk(clk), .reset(rst_n), .start(start_b), .abort(abort_b),
    .num_blocks(num_b), .core_done(core_done_b), .core_start(core_start_b),
    .core_reset(core_reset_b), .core_block_id(id_b),
    .blocks_dispatched(disp_b), .blocks_done(bdone_b),
    .busy(busy_b), .done(done_b), .fsm_state(state_b)
  );

  // ---------------- core responder model ----------------
  // Each core raises a done level LAT cycles after its start rises and
  // holds it until its next reset pulse.
  logic       manual_mode = 1'b0;
  logic [1:0] manual_done = 2'b00;
  logic [1:0] cs [2];
  logic [1:0] cr [2];
  logic [1:0] md [2];
  int         cnt [2][2];

  assign cs[0] = core_start_a;
  assign cs[1] = core_start_b;
  assign cr[0] = core_reset_a;
  assign cr[1] = core_reset_b;
  assign core_done_a = manual_mode ? manual_done : md[0];
  assign core_done_b = md[1];

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 2; i++) begin
        if (!rst_n || cr[d][i]) begin
          md[d][i]  <= 1'b0;
          cnt[d][i] <= 0;
        end else if (cs[d][i] && !md[d][i]) begin
          if (cnt[d][i] == LAT - 1) md[d][i] <= 1'b1;
          else cnt[d][i] <= cnt[d][i] + 1;
        end
      end
    end
  end

  // ---------------- dispatch monitors ----------------
  logic [7:0] id_log_a[$];
  int         core_log_a[$];
  logic [7:0] id_log_b[$];
  int         act_a = 0;
  int         overlap_a = 0;
  logic [1:0] outst_a = '0;
  logic [1:0] seen_a = '0;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (core_start_a[i] || core_reset_a[i]) act_a++;
      if (!rst_n || core_reset_a == 2'b11) begin
        outst_a[i] = 1'b0;
        seen_a[i]  = 1'b0;
      end else if (core_reset_a[i]) begin
        if (outst_a[i]) overlap_a++;
        outst_a[i] = 1'b1;
        seen_a[i]  = 1'b0;
        id_log_a.push_back(id_a[i]);
        core_log_a.push_back(i);
      end else if (outst_a[i]) begin
        if (core_start_a[i]) seen_a[i] = 1'b1;
        else if (seen_a[i]) outst_a[i] = 1'b0;
      end
      if (rst_n && core_reset_b[i] && core_reset_b != 2'b11)
        id_log_b.push_back({5'd0, id_b[i]});
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Table of kernels: block count, cycles from start-sample to done,
  // and the core that receives dispatch k in bit k.
  typedef struct {
    logic [8:0] num;
    int         cycles;
    logic [7:0] seq;
  } row_t;

  row_t rows [5];

  // Watchdog so the run always terminates.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int base, abase, cyc;

    rows[0] = '{9'd1, 8,  8'h00};
    rows[1] = '{9'd2, 9,  8'h02};
    rows[2] = '{9'd5, 24, 8'h0A};
    rows[3] = '{9'd0, 1,  8'h00};
    rows[4] = '{9'd3, 16, 8'h02};

    // Reset values.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_state", state_a, IDLE);
    chk("rst_outputs", {core_start_a, core_reset_a, id_a, disp_a, bdone_a, busy_a, done_a}, '0);
    chk("rst_outputs_b", {core_start_b, core_reset_b, id_b, disp_b, bdone_b, busy_b, done_b}, '0);

    // Table-driven kernels on DUT A.
    for (int r = 0; r < 5; r++) begin
      base  = id_log_a.size();
      abase = act_a;
      start_a = 1'b1;
      num_a   = rows[r].num;
      @(negedge clk);
      start_a = 1'b0;
      cyc = 1;
      while (!done_a && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      chk("row_cycles", cyc, rows[r].cycles);
      chk("row_done", done_a, 1'b1);
      chk("row_busy", busy_a, 1'b0);
      chk("row_blocks_done", bdone_a, rows[r].num);
      chk("row_dispatched", disp_a, rows[r].num);
      chk("row_log_len", id_log_a.size() - base, rows[r].num);
      for (int k = 0; k < int'(rows[r].num) && base + k < id_log_a.size(); k++) begin
        chk("row_id", id_log_a[base+k], k);
        chk("row_core", core_log_a[base+k], rows[r].seq[k]);
      end
      if (rows[r].num == 0) chk("zero_activity", act_a - abase, 0);
      chk("row_overlap", overlap_a, 0);
      @(negedge clk);
    end

    // Both cores complete in the same cycle with three blocks pending.
    manual_mode = 1'b1;
    manual_done = 2'b00;
    start_a = 1'b1;
    num_a   = 9'd5;
    @(negedge clk);                      // n+1
    start_a = 1'b0;
    chk("dual_busy", busy_a, 1'b1);
    @(negedge clk);                      // n+2
    chk("dual_reset0", core_reset_a, 2'b01);
    chk("dual_id0", id_a[0], 8'd0);
    @(negedge clk);                      // n+3
    chk("dual_reset1", core_reset_a, 2'b10);
    chk("dual_id1", id_a[1], 8'd1);
    chk("dual_start0", core_start_a, 2'b01);
    @(negedge clk);                      // n+4
    chk("dual_start_both", core_start_a, 2'b11);
    chk("dual_bdone_before", bdone_a, 9'd0);
    manual_done = 2'b11;
    @(negedge clk);                      // n+5
    manual_done = 2'b00;
    chk("dual_start_drop", core_start_a, 2'b00);
    chk("dual_bdone_plus2", bdone_a, 9'd2);
    chk("dual_no_redispatch", core_reset_a, 2'b00);
    @(negedge clk);                      // n+6
    chk("dual_still_free_wait", core_reset_a, 2'b00);
    @(negedge clk);                      // n+7
    chk("dual_next_core0", core_reset_a, 2'b01);
    chk("dual_next_id0", id_a[0], 8'd2);
    @(negedge clk);                      // n+8
    chk("dual_next_core1", core_reset_a, 2'b10);
    chk("dual_next_id1", id_a[1], 8'd3);
    chk("dual_dispatched", disp_a, 9'd4);
    abort_a = 1'b1;
    @(negedge clk);                      // n+9
    abort_a = 1'b0;
    chk("dual_abort_reset", core_reset_a, 2'b11);
    chk("dual_abort_start", core_start_a, 2'b00);
    chk("dual_abort_state", state_a, IDLE);
    chk("dual_abort_flags", {busy_a, done_a}, 2'b00);
    chk("dual_abort_counts", {disp_a, bdone_a}, {9'd4, 9'd2});
    @(negedge clk);                      // n+10
    chk("dual_abort_pulse_end", core_reset_a, 2'b00);

    // Abort two cycles after the first dispatch, colliding with a completion.
    start_a = 1'b1;
    num_a   = 9'd5;
    @(negedge clk);                      // n+1
    start_a = 1'b0;
    @(negedge clk);                      // n+2
    @(negedge clk);                      // n+3
    chk("abort_start0", core_start_a, 2'b01);
    @(negedge clk);                      // n+4
    manual_done = 2'b01;
    abort_a     = 1'b1;
    @(negedge clk);                      // n+5
    abort_a     = 1'b0;
    manual_done = 2'b00;
    chk("abort_reset_all", core_reset_a, 2'b11);
    chk("abort_start_low", core_start_a, 2'b00);
    chk("abort_state", state_a, IDLE);
    chk("abort_done_low", done_a, 1'b0);
    chk("abort_counts", {disp_a, bdone_a}, {9'd2, 9'd0});
    @(negedge clk);                      // n+6
    chk("abort_reset_once", core_reset_a, 2'b00);
    chk("abort_counts_hold", {disp_a, bdone_a}, {9'd2, 9'd0});
    chk("abort_idle_hold", state_a, IDLE);
    manual_mode = 1'b0;

    // Full-range kernel on the 3-bit-ID instance, then a relaunch from DONE.
    base = id_log_b.size();
    start_b = 1'b1;
    num_b   = 4'd8;
    @(negedge clk);
    start_b = 1'b0;
    cyc = 1;
    while (!done_b && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("full_done", done_b, 1'b1);
    chk("full_dispatched", disp_b, 4'd8);
    chk("full_blocks_done", bdone_b, 4'd8);
    chk("full_log_len", id_log_b.size() - base, 8);
    for (int k = 0; base + k < id_log_b.size(); k++) chk("full_id", id_log_b[base+k], k);
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("relaunch_cleared", {disp_b, bdone_b}, 8'h00);
    chk("relaunch_flags", {busy_b, done_b}, 2'b10);
    cyc = 1;
    while (!done_b && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("relaunch_done", done_b, 1'b1);
    chk("relaunch_blocks_done", bdone_b, 4'd8);

    // Asynchronous reset between edges while running.
    start_a = 1'b1;
    num_a   = 9'd5;
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    chk("areset_running", disp_a, 9'd2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_outputs", {core_start_a, core_reset_a, id_a, disp_a, bdone_a, busy_a, done_a}, '0);
    chk("areset_state", state_a, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("areset_after", {state_a, core_reset_a, core_start_a}, {IDLE, 2'b00, 2'b00});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
